uart_rx_framer: RTL
===================

Name: uart_rx_framer

Overview:
- Receive end of the rover's serial link from the onboard computer: 8-bit, LSB-first UART.
- Oversamples the asynchronous rx line, validates start and stop bits, and queues received bytes in a small FIFO.
- Presents bytes to the command decoder over a valid/ready interface.
- Flags framing errors and overruns so the command layer can drop corrupt packets.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even, >=8.
- FIFO_DEPTH, 4, byte entries; power of two, >=2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- rx_i  in  1  asynchronous serial line; idle high.
- rx_data_o  out  8  FIFO head byte.
- rx_valid_o  out  1  FIFO non-empty.
- rx_ready_i  in  1  consumer accepts head when valid&ready.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: byte dropped, FIFO full.
- busy_o  out  1  FSM not in IDLE.
- fill_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: all outputs 0; rx_data_o is 0x00; synchronizer flops reset to 1; FSM to IDLE; FIFO empty; tick counter 0.
- Synchronizer: 2-flop on rx_i; all logic uses the synced value rxs.
- Tick generator: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), minimum 1.
  - Counter 0..DIV-1 emits a one-cycle tick at wrap.
  - Counter restarts at 0 on the IDLE->START transition.
- Sample counter scnt counts ticks within the current bit.
- FSM, ticks only advance non-IDLE states:
  - IDLE: rxs==0 -> START, scnt=0.
  - START: at scnt==OVERSAMPLE/2-1, sample rxs.
    - rxs==0 -> DATA, bit index 0, scnt=0.
    - rxs==1 -> IDLE; glitch, no flag.
  - DATA: at each scnt==OVERSAMPLE-1, shift rxs into bit[idx], LSB first; after idx 7 -> STOP (or PARITY when the optional feature is enabled).
  - STOP: at scnt==OVERSAMPLE-1, sample rxs.
    - rxs==1: push byte; if FIFO full, drop and pulse overrun_o. -> IDLE.
    - rxs==0: pulse frame_err_o, discard byte -> BRK.
  - BRK: wait for rxs==1 (no tick needed) -> IDLE; prevents a break condition retriggering.
- Latency: rx_valid_o rises the cycle after the stop-bit sample cycle.
- FIFO:
  - Registered write/read pointers (wrap mod FIFO_DEPTH) plus count.
  - rx_data_o = mem[rd_ptr], held stable while valid & !ready.
  - Pop on valid&ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push when full with a simultaneous pop is accepted (no overrun).
- fill_o reflects count after each edge.
- Reset asserted mid-frame: immediate return to IDLE; partial byte and FIFO contents lost; no flags.
- frame_err_o and overrun_o are never both asserted in the same cycle.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Extra state PARITY between DATA and STOP samples the 9th bit.
  - Even parity expected (XOR of 8 data bits == parity bit).
  - Mismatch sets an internal parity_bad flag; at STOP the byte is discarded and parity_err_o pulses one cycle (new output port, 1 bit), unless the stop bit is also bad, in which case only frame_err_o pulses.
- When undefined: no PARITY state, no parity_err_o port; frame is 8N1.

Test Plan (CLK_HZ=1600000, BAUD=100000, OVERSAMPLE=16 -> DIV=1, 16 clk/bit; FIFO_DEPTH=4):
- Send 0xA5 8N1, rx_ready_i=1 -> rx_valid_o one cycle, rx_data_o=0xA5, fill_o back to 0, no error pulses.
- rx_i low for 3 clk then high -> FSM returns to IDLE, busy_o drops, no valid, no frame_err_o.
- Send 0x3C with stop bit 0, then hold line low for 40 clk -> frame_err_o single pulse, no valid, busy_o high until line returns high.
- rx_ready_i=0, send 0x01..0x05 -> fill_o=4, overrun_o one pulse on 5th byte; then ready=1 drains 0x01,0x02,0x03,0x04 in order.
- Assert rst midway through bit 4 of 0xFF -> all outputs 0 next cycle; following 0x5A received correctly.
- UART_RX_PARITY_EN: send 0x07 with parity 1 -> valid, data 0x07; with parity 0 -> parity_err_o pulse, no valid.

Source files
------------

// File: rtl/uart_rx_framer_if.sv
// Byte stream from the UART receive framer to the command decoder.
// valid/ready handshake: a byte transfers on any cycle where both are high.
interface uart_rx_framer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_framer.sv
// 8-bit LSB-first UART receiver with oversampled framing, error flags and a byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the parity_err_o port.
module uart_rx_framer #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_i,
    uart_rx_framer_if.master            rx_if,
    output logic                        frame_err_o,
    output logic                        overrun_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fill_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                        parity_err_o
`endif
);

    localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TCNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCNT_W  = $clog2(OVERSAMPLE);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int FW      = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BRK    = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity: the XOR of the data bits must equal the received parity bit.
    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic              sync1_r;
    logic              rxs_r;
    logic [TCNT_W-1:0] tcnt_r;
    logic              tick_s;
    state_t            state_r, state_s;
    logic [SCNT_W-1:0] scnt_r, scnt_s;
    logic [2:0]        idx_r, idx_s;
    logic [7:0]        shreg_r, shreg_s;
    logic              parity_bad_r, parity_bad_s;
    logic              push_s, frame_err_s, parity_err_s;
    logic              frame_err_r, overrun_r, parity_err_r;
    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PW-1:0]     wr_r, rd_r;
    logic [FW-1:0]     cnt_r;
    logic              full_s, pop_s, push_ok_s, overrun_s;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rx_i;
            rxs_r   <= sync1_r;
        end
    end

    assign tick_s = (state_r != S_IDLE) && (tcnt_r == TCNT_W'(DIV - 1));

    // Oversample tick divider; held at zero in IDLE so each frame starts phase-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_r <= '0;
        end else if ((state_r == S_IDLE) || tick_s) begin
            tcnt_r <= '0;
        end else begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
        end
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            scnt_r       <= '0;
            idx_r        <= 3'd0;
            shreg_r      <= 8'h00;
            parity_bad_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            scnt_r       <= scnt_s;
            idx_r        <= idx_s;
            shreg_r      <= shreg_s;
            parity_bad_r <= parity_bad_s;
        end
    end

    // Frame FSM next state: start at mid-bit, data/parity/stop at the last tick of each bit.
    always_comb begin
        state_s      = state_r;
        scnt_s       = scnt_r;
        idx_s        = idx_r;
        shreg_s      = shreg_r;
        parity_bad_s = parity_bad_r;
        push_s       = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!rxs_r) begin
                    state_s      = S_START;
                    scnt_s       = '0;
                    parity_bad_s = 1'b0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s && (scnt_r == SCNT_W'(OVERSAMPLE / 2 - 1))) begin
                    // A start bit that is high again at mid-bit is a glitch.
                    state_s = rxs_r ? S_IDLE : S_DATA;
                    idx_s   = 3'd0;
                    scnt_s  = '0;
                end else if (tick_s) begin
                    scnt_s = scnt_r + SCNT_W'(1);
                end else begin
                    scnt_s = scnt_r;
                end
            end
            S_DATA: begin
                if (tick_s && (scnt_r == SCNT_W'(OVERSAMPLE - 1))) begin
                    shreg_s = {rxs_r, shreg_r[7:1]};
                    scnt_s  = '0;
                    if (idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else if (tick_s) begin
                    scnt_s = scnt_r + SCNT_W'(1);
                end else begin
                    scnt_s = scnt_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_s && (scnt_r == SCNT_W'(OVERSAMPLE - 1))) begin
                    parity_bad_s = (parity8(shreg_r) != rxs_r);
                    scnt_s       = '0;
                    state_s      = S_STOP;
                end else if (tick_s) begin
                    scnt_s = scnt_r + SCNT_W'(1);
                end else begin
                    scnt_s = scnt_r;
                end
            end
`endif
            S_STOP: begin
                if (tick_s && (scnt_r == SCNT_W'(OVERSAMPLE - 1))) begin
                    scnt_s = '0;
                    if (rxs_r) begin
                        state_s      = S_IDLE;
                        push_s       = !parity_bad_r;
                        parity_err_s = parity_bad_r;
                    end else begin
                        // Low stop bit: framing error wins over parity; wait out any break.
                        state_s     = S_BRK;
                        frame_err_s = 1'b1;
                    end
                end else if (tick_s) begin
                    scnt_s = scnt_r + SCNT_W'(1);
                end else begin
                    scnt_s = scnt_r;
                end
            end
            S_BRK: begin
                if (rxs_r) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_BRK;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    assign full_s    = (cnt_r == FW'(FIFO_DEPTH));
    assign pop_s     = rx_if.rx_valid && rx_if.rx_ready;
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign overrun_s = push_s && full_s && !pop_s;

    // Byte FIFO: storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_r  <= '0;
            rd_r  <= '0;
            cnt_r <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_r] <= shreg_r;
                wr_r        <= wr_r + PW'(1);
            end else begin
                wr_r <= wr_r;
            end
            if (pop_s) begin
                rd_r <= rd_r + PW'(1);
            end else begin
                rd_r <= rd_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   cnt_r <= cnt_r + FW'(1);
                2'b01:   cnt_r <= cnt_r - FW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Registered one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            frame_err_r  <= frame_err_s;
            overrun_r    <= overrun_s;
            parity_err_r <= parity_err_s;
        end
    end

    assign rx_if.rx_data  = mem_r[rd_r];
    assign rx_if.rx_valid = (cnt_r != '0);
    assign fill_o         = cnt_r;
    assign busy_o         = (state_r != S_IDLE);
    assign frame_err_o    = frame_err_r;
    assign overrun_o      = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o   = parity_err_r;
`endif

endmodule
